// File: rtl/fetch_sequencer.sv
// fetch_sequencer: one-hot bus/load strobe sequencer for fetch steps T0..T2, T1 stretched by mem_ready.
// Define FETCH_TIMEOUT_EN to bound the read wait at WAIT_MAX cycles, after which it enters a sticky FAULT.
module fetch_sequencer #(
   parameter int WAIT_MAX = 15
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_run,
   input  logic        i_mem_ready,
   input  logic        i_exec_done,
   output logic        o_pc_out,
   output logic        o_zlow_out,
   output logic        o_mdr_out,
   output logic        o_mar_in,
   output logic        o_inc_pc,
   output logic        o_z_in,
   output logic        o_pc_in,
   output logic        o_read,
   output logic        o_mdr_in,
   output logic        o_ir_in,
   output logic        o_executing,
   output logic        o_mem_fault,
   output logic [31:0] o_fetch_count
);
   typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_EXEC, S_FAULT} state_t;
   state_t      r_state, w_next;
   logic [31:0] r_fetch_count;
   logic        w_timeout;

   if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
      $error("WAIT_MAX must be within 1..255");
   end

`ifdef FETCH_TIMEOUT_EN
   logic [7:0] r_wait;
   // Counter holds the number of not-ready T1W cycles already spent.
   always_ff @(posedge i_clock) begin
      if (i_reset || r_state == S_T1) r_wait <= '0;
      else if (r_state == S_T1W && !i_mem_ready) r_wait <= r_wait + 8'd1;
   end
   assign w_timeout   = !i_mem_ready && r_wait == 8'(WAIT_MAX - 1);
   assign o_mem_fault = r_state == S_FAULT;
`else
   assign w_timeout   = 1'b0;
   assign o_mem_fault = 1'b0;
`endif

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_fetch_count <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_T2) r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = i_run ? S_T0 : S_IDLE;
         S_T0:    w_next = S_T1;
         S_T1:    w_next = S_T1W;
         S_T1W:   w_next = i_mem_ready ? S_T2 : (w_timeout ? S_FAULT : S_T1W);
         S_T2:    w_next = S_EXEC;
         S_EXEC:  w_next = !i_exec_done ? S_EXEC : (i_run ? S_T0 : S_IDLE);
         default: w_next = r_state;
      endcase
   end

   // Bus enables decode from distinct states, so at most one can ever be high.
   assign o_pc_out      = r_state == S_T0;
   assign o_zlow_out    = r_state == S_T1;
   assign o_mdr_out     = r_state == S_T2;
   assign o_mar_in      = r_state == S_T0;
   assign o_inc_pc      = r_state == S_T0;
   assign o_z_in        = r_state == S_T0;
   assign o_pc_in       = r_state == S_T1;
   assign o_read        = r_state == S_T1 || r_state == S_T1W;
   assign o_mdr_in      = r_state == S_T1W && i_mem_ready;
   assign o_ir_in       = r_state == S_T2;
   assign o_executing   = r_state == S_EXEC;
   assign o_fetch_count = r_fetch_count;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus, per-cycle comparison against a phase-level fetch model.
module tb_fetch_sequencer;
   localparam int WM = 15;
   logic clk = 1'b0, rst = 1'b1, run = 1'b0, ready = 1'b1, done = 1'b0;
   logic pc_out, zlow_out, mdr_out, mar_in, inc_pc, z_in, pc_in, rd, mdr_in, ir_in, executing, mem_fault;
   logic [31:0] fetch_count;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.WAIT_MAX(WM)) dut (
      .i_clock(clk), .i_reset(rst), .i_run(run), .i_mem_ready(ready), .i_exec_done(done),
      .o_pc_out(pc_out), .o_zlow_out(zlow_out), .o_mdr_out(mdr_out), .o_mar_in(mar_in),
      .o_inc_pc(inc_pc), .o_z_in(z_in), .o_pc_in(pc_in), .o_read(rd), .o_mdr_in(mdr_in),
      .o_ir_in(ir_in), .o_executing(executing), .o_mem_fault(mem_fault), .o_fetch_count(fetch_count)
   );

   // Model phases: 0 idle, 1 T0, 2 T1, 3 read-wait, 4 T2, 5 exec, 6 fault.
   int ph = 0;
   bit m_valid = 1'b0;
   logic [31:0] m_cnt = '0, m_off = '0;
`ifdef FETCH_TIMEOUT_EN
   int wc = 0;
`endif
   always @(posedge clk) begin
      if (rst) begin
         ph <= 0;
         m_cnt <= '0;
         m_valid <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
         wc <= 0;
`endif
      end else begin
         case (ph)
            0: if (run) ph <= 1;
            1: ph <= 2;
            2: begin
               ph <= 3;
`ifdef FETCH_TIMEOUT_EN
               wc <= 0;
`endif
            end
            3: begin
               if (ready) ph <= 4;
`ifdef FETCH_TIMEOUT_EN
               else if (wc + 1 == WM) ph <= 6;
               wc <= ready ? wc : wc + 1;
`endif
            end
            4: begin
               ph <= 5;
               m_cnt <= m_cnt + 32'd1;
            end
            5: if (done) ph <= run ? 1 : 0;
            default: ;
         endcase
      end
   end

   function automatic logic [11:0] exp_out(input int p, input logic r);
      return {p == 1, p == 2, p == 4, p == 1, p == 1, p == 1, p == 2, p == 2 || p == 3, p == 3 && r, p == 4, p == 5, p == 6};
   endfunction

   function automatic logic [11:0] act_out();
      return {pc_out, zlow_out, mdr_out, mar_in, inc_pc, z_in, pc_in, rd, mdr_in, ir_in, executing, mem_fault};
   endfunction

   // Every clock: compare against the model at the falling edge, then advance past the rising edge.
   task automatic tick();
      @(negedge clk);
      if (m_valid) begin
         checks++;
         if (act_out() !== exp_out(ph, ready)) begin
            failures++;
            $display("FAIL strobes t=%0t got=%b want=%b", $time, act_out(), exp_out(ph, ready));
         end
         checks++;
         if (fetch_count !== m_cnt + m_off) begin
            failures++;
            $display("FAIL count t=%0t got=%h want=%h", $time, fetch_count, m_cnt + m_off);
         end
         checks++;
         if ($countones({pc_out, zlow_out, mdr_out}) > 1) begin
            failures++;
            $display("FAIL bus_onehot t=%0t got=%b want=at most one", $time, {pc_out, zlow_out, mdr_out});
         end
      end
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic wait_for(input string what);
      for (int i = 0; i < 40; i++) begin
         if ((what == "exec" && executing) || (what == "t1" && zlow_out) || (what == "t2" && mdr_out)) return;
         tick();
      end
      failures++;
      $display("FAIL wait_%s got=timeout want=reached", what);
   endtask

   initial begin
      int nread, nmdr, npc;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_outputs", {20'd0, act_out(), fetch_count}, 64'd0);
      run = 1'b1;
      tick();
      chk("t0_after_run", {63'd0, pc_out}, 64'd1);
      for (int k = 1; k <= 3; k++) begin
         wait_for("exec");
         chk("count_after_fetch", {32'd0, fetch_count}, 64'(k));
         tick();
         tick();
         done = 1'b1;
         tick();
         done = 1'b0;
      end
      chk("back_to_back_t0", {63'd0, pc_out}, 64'd1);
      ready = 1'b0;
      tick();
      nread = 0;
      nmdr = 0;
      for (int j = 0; j < 4; j++) begin
         tick();
         if (j == 3) begin
            ready = 1'b1;
            #1;
         end
         nread += int'(rd);
         nmdr += int'(mdr_in);
      end
      chk("wait_read_cycles", 64'(nread), 64'd4);
      chk("wait_mdrin_cycles", 64'(nmdr), 64'd1);
      tick();
      chk("irin_after_ready", {62'd0, ir_in, mdr_in}, 64'd2);
      wait_for("exec");
      done = 1'b1;
      tick();
      done = 1'b0;
      ready = 1'b0;
      repeat (21) tick();
`ifdef FETCH_TIMEOUT_EN
      chk("timeout_fault", {63'd0, mem_fault}, 64'(WM <= 20));
`else
      chk("no_timeout", {62'd0, mem_fault, rd}, 64'd1);
`endif
      rst = 1'b1;
      ready = 1'b1;
      tick();
      rst = 1'b0;
      chk("reset_from_wait", {20'd0, act_out(), fetch_count}, 64'd0);
      tick();
      chk("t0_after_reset", {63'd0, pc_out}, 64'd1);
      wait_for("t1");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("reset_in_t1", {20'd0, act_out(), fetch_count}, 64'd0);
      tick();
      chk("t0_after_t1_reset", {63'd0, pc_out}, 64'd1);
      wait_for("t1");
      run = 1'b0;
      wait_for("exec");
      chk("fetch_completes", {32'd0, fetch_count}, 64'd1);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("idle_after_exec", {52'd0, act_out()}, 64'd0);
      npc = 0;
      repeat (6) begin
         tick();
         npc += int'(pc_out);
      end
      chk("no_pcout_idle", 64'(npc), 64'd0);
      run = 1'b1;
      wait_for("t2");
      force dut.r_fetch_count = 32'hFFFF_FFFF;
      m_off = 32'hFFFF_FFFF - m_cnt;
      #1 release dut.r_fetch_count;
      tick();
      chk("count_wrap", {32'd0, fetch_count}, 64'd0);
      run = 1'b0;
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
